// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: TMS-decoded state machine, instruction register,
// IDCODE hand-off to the 32-bit serial transmitter and TDO multiplexing.
module jtag_tap_controller #(
   parameter int                  IR_WIDTH     = 4,
   parameter logic [31:0]         IDCODE_VALUE = 32'h1BEEF0D7,
   parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0001,
   parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tms,
   input  logic                tdi,
   input  logic                tx_out,
   input  logic                tx_done,
   output logic                tx_enable,
   output logic [31:0]         tx_data,
   output logic                tdo,
   output logic [3:0]          state,
   output logic [IR_WIDTH-1:0] ir,
   output logic                shift_dr,
   output logic                capture_dr,
   output logic                update_dr,
   output logic                shift_ir
);

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SHIFT_DR = 4'h2,
      EXIT1_DR = 4'h1,
      PAUSE_DR = 4'h3,
      EXIT2_DR = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SHIFT_IR = 4'hA,
      EXIT1_IR = 4'h9,
      PAUSE_IR = 4'hB,
      EXIT2_IR = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_t;

   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

   function automatic tap_state_t next_state(input tap_state_t s, input logic t);
      case (s)
         TLR:      return t ? TLR      : RTI;
         RTI:      return t ? SEL_DR   : RTI;
         SEL_DR:   return t ? SEL_IR   : CAP_DR;
         CAP_DR:   return t ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: return t ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: return t ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return t ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: return t ? UPD_DR   : SHIFT_DR;
         UPD_DR:   return t ? SEL_DR   : RTI;
         SEL_IR:   return t ? TLR      : CAP_IR;
         CAP_IR:   return t ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: return t ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: return t ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return t ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: return t ? UPD_IR   : SHIFT_IR;
         UPD_IR:   return t ? SEL_DR   : RTI;
         default:  return TLR;
      endcase
   endfunction

   tap_state_t          cur_state;
   tap_state_t          nxt_state;
   logic [IR_WIDTH-1:0] ir_shift;
   logic                bypass_reg;
   logic                tdo_r;
   logic                tdo_next;
   logic                idcode_sel;
   logic                unused_tx_done;

   assign nxt_state      = next_state(cur_state, tms);
   assign unused_tx_done = tx_done;

   // The all-ones opcode is always BYPASS, even if IDCODE_INSTR is misconfigured to match it.
   assign idcode_sel = (ir == IDCODE_INSTR) && (ir != BYPASS_INSTR);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state  <= TLR;
         ir         <= IDCODE_INSTR;
         ir_shift   <= '0;
         bypass_reg <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         case (cur_state)
            CAP_IR:   ir_shift <= IR_CAPTURE;
            SHIFT_IR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            CAP_DR:   if (!idcode_sel) bypass_reg <= 1'b0;
            SHIFT_DR: if (!idcode_sel) bypass_reg <= tdi;
            default:  ;
         endcase
         if (nxt_state == TLR)
            ir <= IDCODE_INSTR;
         else if (cur_state == UPD_IR)
            ir <= ir_shift;
      end
   end

   // NOTE: give every always_comb output a default first so no path infers a latch.
   always_comb begin
      tdo_next = 1'b0;
      if (cur_state == SHIFT_IR)
         tdo_next = ir_shift[0];
      else if ((cur_state == SHIFT_DR) && !idcode_sel)
         tdo_next = bypass_reg;
   end

   // TDO changes on the falling edge so the external tester samples it stably on the rising edge.
   always_ff @(negedge clk) begin
      if (reset)
         tdo_r <= 1'b0;
      else
         tdo_r <= tdo_next;
   end

   assign tx_enable  = idcode_sel && ((cur_state == SHIFT_DR) || (cur_state == EXIT1_DR));
   assign tx_data    = idcode_sel ? IDCODE_VALUE : 32'h0;
   assign tdo        = tx_enable ? tx_out : tdo_r;

   assign state      = cur_state;
   assign shift_dr   = (cur_state == SHIFT_DR);
   assign capture_dr = (cur_state == CAP_DR);
   assign update_dr  = (cur_state == UPD_DR);
   assign shift_ir   = (cur_state == SHIFT_IR);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: directed scenarios plus random TAP traffic
// compared every cycle against a table-driven reference model and a transmitter stub.
module tb_jtag_tap_controller;

   localparam logic [31:0] ID_VAL = 32'h1BEEF0D7;
   localparam logic [3:0]  ID_OP  = 4'b0001;
   localparam logic [3:0]  BY_OP  = 4'b1111;

   // Next-state tables indexed by state code, for tms=0 and tms=1.
   localparam logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                        4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   localparam logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                        4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

   logic        clk = 1'b0;
   logic        reset, tms, tdi;
   logic        tx_out = 1'b0;
   logic        tx_done = 1'b0;
   logic        tx_enable;
   logic [31:0] tx_data;
   logic        tdo;
   logic [3:0]  state;
   logic [3:0]  ir;
   logic        shift_dr, capture_dr, update_dr, shift_ir;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   jtag_tap_controller dut (
      .clk(clk), .reset(reset), .tms(tms), .tdi(tdi),
      .tx_out(tx_out), .tx_done(tx_done), .tx_enable(tx_enable), .tx_data(tx_data),
      .tdo(tdo), .state(state), .ir(ir),
      .shift_dr(shift_dr), .capture_dr(capture_dr), .update_dr(update_dr), .shift_ir(shift_ir)
   );

   // Transmitter stub: emits tx_data MSB first on negedges while enabled, zeros after 32 bits.
   int tx_cnt = 0;
   always @(negedge clk) begin
      if (tx_enable === 1'b1) begin
         tx_out  <= (tx_cnt < 32) ? tx_data[31 - tx_cnt] : 1'b0;
         tx_done <= (tx_cnt >= 31);
         tx_cnt  <= tx_cnt + 1;
      end else begin
         tx_out  <= 1'b0;
         tx_done <= 1'b0;
         tx_cnt  <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state.
   logic [3:0]  m_st   = 4'hF;
   logic [3:0]  m_ir   = ID_OP;
   logic [3:0]  m_irs  = 4'h0;
   logic        m_byp  = 1'b0;
   logic        m_tdor = 1'b0;
   logic        m_bit  = 1'b0;
   logic        m_en   = 1'b0;
   int          m_cnt  = 0;
   logic [31:0] id_word = ID_VAL;

   task automatic model_posedge(input logic t, input logic d, input logic r);
      logic [3:0] nst;
      if (r) begin
         m_st = 4'hF; m_ir = ID_OP; m_irs = 4'h0; m_byp = 1'b0;
      end else begin
         nst = t ? NXT1[m_st] : NXT0[m_st];
         if (m_st == 4'hE) m_irs = 4'b0001;
         if (m_st == 4'hA) m_irs = {d, m_irs[3:1]};
         if (m_st == 4'h6 && m_ir != ID_OP) m_byp = 1'b0;
         if (m_st == 4'h2 && m_ir != ID_OP) m_byp = d;
         if (nst == 4'hF)       m_ir = ID_OP;
         else if (m_st == 4'hD) m_ir = m_irs;
         m_st = nst;
      end
   endtask

   task automatic model_negedge(input logic r);
      m_en = (m_ir == ID_OP) && (m_st == 4'h2 || m_st == 4'h1);
      if (r)                                 m_tdor = 1'b0;
      else if (m_st == 4'hA)                 m_tdor = m_irs[0];
      else if (m_st == 4'h2 && m_ir != ID_OP) m_tdor = m_byp;
      else                                   m_tdor = 1'b0;
      if (m_en) begin
         m_bit = (m_cnt < 32) ? id_word[31 - m_cnt] : 1'b0;
         m_cnt++;
      end else begin
         m_cnt = 0;
      end
   endtask

   task automatic compare_all();
      check("state",      {28'h0, state},      {28'h0, m_st});
      check("ir",         {28'h0, ir},         {28'h0, m_ir});
      check("tx_enable",  {31'h0, tx_enable},  {31'h0, m_en});
      check("tx_data",    tx_data,             (m_ir == ID_OP) ? ID_VAL : 32'h0);
      check("tdo",        {31'h0, tdo},        {31'h0, (m_en ? m_bit : m_tdor)});
      check("shift_dr",   {31'h0, shift_dr},   {31'h0, (m_st == 4'h2)});
      check("capture_dr", {31'h0, capture_dr}, {31'h0, (m_st == 4'h6)});
      check("update_dr",  {31'h0, update_dr},  {31'h0, (m_st == 4'h5)});
      check("shift_ir",   {31'h0, shift_ir},   {31'h0, (m_st == 4'hA)});
   endtask

   // One TCK cycle: drive, clock the model with the DUT, check after the falling edge.
   task automatic step(input logic t, input logic d, input logic r);
      tms = t; tdi = d; reset = r;
      @(posedge clk);
      model_posedge(t, d, r);
      @(negedge clk);
      model_negedge(r);
      #1;
      compare_all();
   endtask

   task automatic goto_rti();
      for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
      check("five_tms_tlr", {28'h0, state}, 32'hF);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // From RTI: capture, shift op LSB first, update; abort resets before the update.
   task automatic load_ir(input logic [3:0] op, input bit abort, output logic [3:0] seen);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         seen[i] = tdo;
         step(!abort && (i == 3), op[i], 1'b0);
      end
      if (abort) begin
         step(1'($urandom), 1'b0, 1'b1);
      end else begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
   endtask

   // From RTI: DR scan of len shift cycles, optionally pausing at shift pause_at.
   task automatic dr_scan(input int len, input int pause_at);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
         if (i == pause_at && i < len - 1) begin
            step(1'b1, 1'($urandom), 1'b0);
            for (int p = 0; p < 1 + $urandom_range(0, 2); p++) step(1'b0, 1'($urandom), 1'b0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
         end else begin
            step(i == len - 1, 1'($urandom), 1'b0);
         end
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin : main
      logic [31:0] word;
      logic        any_one;
      logic [3:0]  seen;
      logic [3:0]  pat;
      logic [3:0]  op;
      bit          abort;

      reset = 1'b1; tms = 1'b1; tdi = 1'b0;

      // Reset with tms high.
      step(1'b1, 1'b0, 1'b1);
      check("rst_state", {28'h0, state}, 32'hF);
      check("rst_ir",    {28'h0, ir},    {28'h0, ID_OP});
      check("rst_tdo",   {31'h0, tdo},   32'h0);
      step(1'b0, 1'b0, 1'b0);

      // IDCODE scan: 32 bits MSB first, then zeros.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("idcode_en", {31'h0, tx_enable}, 32'h1);
      word = 32'h0;
      word[31] = tdo;
      for (int k = 30; k >= 0; k--) begin
         step(1'b0, 1'b0, 1'b0);
         word[k] = tdo;
      end
      check("idcode_word", word, ID_VAL);
      any_one = 1'b0;
      for (int k = 0; k < 32; k++) begin
         step(1'b0, 1'b0, 1'b0);
         any_one = any_one | (tdo !== 1'b0);
      end
      check("idcode_drain_zero", {31'h0, any_one}, 32'h0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Load BYPASS; tdo shows the capture pattern.
      load_ir(BY_OP, 1'b0, seen);
      check("ir_capture_pat", {28'h0, seen}, 32'h1);
      check("ir_bypass",      {28'h0, ir},   {28'h0, BY_OP});

      // Bypass: tdi 1,0,1,1 appears delayed by one with a leading 0.
      pat = 4'b1101;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         seen[i] = tdo;
         step(i == 3, pat[i], 1'b0);
      end
      check("bypass_delay", {28'h0, seen}, 32'hA);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Back to IDCODE, pause after 8 bits, resume restarts at bit 31.
      load_ir(ID_OP, 1'b0, seen);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("pause_state", {28'h0, state},     32'h3);
      check("pause_en",    {31'h0, tx_enable}, 32'h0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("resume_bit31", {31'h0, tdo}, {31'h0, id_word[31]});
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Reset mid IR shift with 1010 partly shifted: no update.
      load_ir(4'b1010, 1'b1, seen);
      check("abort_state", {28'h0, state}, 32'hF);
      check("abort_ir",    {28'h0, ir},    {28'h0, ID_OP});
      step(1'b0, 1'b0, 1'b0);

      // Random traffic, always starting and ending in RTI.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 7))
            0: begin
               step(1'($urandom), 1'($urandom), 1'b1);
               check("rnd_rst_state", {28'h0, state}, 32'hF);
               step(1'b0, 1'b0, 1'b0);
            end
            1, 2: begin
               op    = $urandom_range(0, 1) ? ID_OP : 4'($urandom);
               abort = ($urandom_range(0, 9) == 0);
               load_ir(op, abort, seen);
               check("rnd_ir_cap", {28'h0, seen}, 32'h1);
               if (abort) step(1'b0, 1'b0, 1'b0);
               else       check("rnd_ir_load", {28'h0, ir}, {28'h0, op});
            end
            3, 4, 5: dr_scan($urandom_range(1, 70), $urandom_range(0, 40));
            default: begin
               for (int i = 0; i < $urandom_range(1, 20); i++)
                  step(1'($urandom), 1'($urandom), 1'b0);
               goto_rti();
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
